// File: rtl/wave_synth_if.sv
// Control and sample bus between the command decoder, the synth core and the DAC/plot consumers.
interface wave_synth_if;
  logic [6:0] frequency;
  logic [3:0] amplitude;
  logic [1:0] wave_type;
  logic [7:0] sample;
  logic       sample_valid;
  logic       cycle_start;

  modport master (
    output frequency, amplitude, wave_type,
    input  sample, sample_valid, cycle_start
  );

  modport slave (
    input  frequency, amplitude, wave_type,
    output sample, sample_valid, cycle_start
  );
endinterface

// File: rtl/wave_synth_core.sv
// Phase-accumulator waveform synthesiser: prescaled tick, shape/scale pipeline, offset-binary samples.
// Settings are shadowed and only reloaded at a phase wrap so a period never changes shape mid-way.
module wave_synth_core #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned SAMPLE_DIV = 50,
  parameter int unsigned INC_UNIT   = 42950
) (
  input  logic       clk,
  input  logic       rst,
  wave_synth_if.slave wave_io
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned P_W   = 8;
  localparam logic [ACC_W-1:0] INC_STEP = ACC_W'(INC_UNIT);

  // Quarter-wave table: round(127*sin(2*pi*i/256)), i = 0..63
  localparam logic [6:0] SINE_Q [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [6:0]        freq_q, freq_d;
  logic [3:0]        amp_q, amp_d;
  logic [1:0]        wave_q, wave_d;
  logic              v0_q, v0_d, wrap_q, wrap_d;
  logic signed [7:0] s1_q, s1_d;
  logic [3:0]        amp1_q, amp1_d;
  logic              v1_q, v1_d, wrap1_q, wrap1_d;
  logic signed [7:0] s2_q, s2_d;
  logic              v2_q, v2_d, wrap2_q, wrap2_d;
  logic [7:0]        sample_q, sample_d;
  logic              valid_q, valid_d, cstart_q, cstart_d;

  logic              tick_c;
  logic [ACC_W-1:0]  inc_c;
  logic [ACC_W:0]    sum_c;
  logic [P_W-1:0]    p_c;
  logic [5:0]        sidx_c;
  logic [7:0]        smag_c;
  logic signed [7:0] shape_c;
  logic signed [11:0] s_ext_c, amp_ext_c, prod_c;

  // Stage 0: prescaler, phase accumulator and wrap-synchronous shadow reload
  always_comb begin
    tick_c = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    inc_c  = ACC_W'(freq_q) * INC_STEP;
    sum_c  = {1'b0, acc_q} + {1'b0, inc_c};
    acc_d  = acc_q;
    freq_d = freq_q;
    amp_d  = amp_q;
    wave_d = wave_q;
    wrap_d = 1'b0;
    v0_d   = tick_c;
    if (tick_c) begin
      if (freq_q != '0) begin
        acc_d  = sum_c[ACC_W-1:0];
        wrap_d = sum_c[ACC_W];
      end
      // A stopped generator reloads every tick so a new frequency starts without a wrap
      if ((freq_q == '0) || sum_c[ACC_W]) begin
        freq_d = wave_io.frequency;
        amp_d  = wave_io.amplitude;
        wave_d = wave_io.wave_type;
      end
    end
  end

  // Stage 1: shape the top phase bits into a signed sample
  always_comb begin
    p_c     = acc_q[ACC_W-1 -: P_W];
    sidx_c  = p_c[6] ? ~p_c[5:0] : p_c[5:0];
    smag_c  = {1'b0, SINE_Q[sidx_c]};
    shape_c = '0;
    case (wave_q)
      2'd0: shape_c = p_c[7] ? 8'sh80 : 8'sh7F;
      2'd1: shape_c = p_c[7] ? (8'd127 - {p_c[6:0], 1'b0}) : ({p_c[6:0], 1'b0} - 8'd128);
      2'd2: shape_c = p_c ^ 8'h80;
      2'd3: shape_c = p_c[7] ? (8'd0 - smag_c) : smag_c;
      default: shape_c = '0;
    endcase
    s1_d    = v0_q ? shape_c : s1_q;
    amp1_d  = v0_q ? amp_q : amp1_q;
    wrap1_d = wrap_q;
    v1_d    = v0_q;
  end

  // Stage 2: gain scaling, floor division by 16
  always_comb begin
    s_ext_c   = 12'(s1_q);
    amp_ext_c = 12'(amp1_q);
    prod_c    = s_ext_c * amp_ext_c;
    s2_d      = v1_q ? 8'(prod_c >>> 4) : s2_q;
    wrap2_d   = wrap1_q;
    v2_d      = v1_q;
  end

  // Stage 3: offset-binary conversion (+128 is an MSB flip) and strobes
  always_comb begin
    sample_d = v2_q ? {~s2_q[7], s2_q[6:0]} : sample_q;
    valid_d  = v2_q;
    cstart_d = v2_q & wrap2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      freq_q   <= '0;
      amp_q    <= '0;
      wave_q   <= '0;
      v0_q     <= 1'b0;
      wrap_q   <= 1'b0;
      s1_q     <= '0;
      amp1_q   <= '0;
      v1_q     <= 1'b0;
      wrap1_q  <= 1'b0;
      s2_q     <= '0;
      v2_q     <= 1'b0;
      wrap2_q  <= 1'b0;
      sample_q <= 8'd128;
      valid_q  <= 1'b0;
      cstart_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      wave_q   <= wave_d;
      v0_q     <= v0_d;
      wrap_q   <= wrap_d;
      s1_q     <= s1_d;
      amp1_q   <= amp1_d;
      v1_q     <= v1_d;
      wrap1_q  <= wrap1_d;
      s2_q     <= s2_d;
      v2_q     <= v2_d;
      wrap2_q  <= wrap2_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      cstart_q <= cstart_d;
    end
  end

  assign wave_io.sample       = sample_q;
  assign wave_io.sample_valid = valid_q;
  assign wave_io.cycle_start  = cstart_q;

endmodule

// File: tb/tb_wave_synth_core.sv
// Self-checking bench for wave_synth_core: tick-level reference model feeding a scoreboard,
// plus per-scenario checks of the documented sample values and cycle lengths.
module tb_wave_synth_core;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned INC   = 2**24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wave_synth_if wif();

  wave_synth_core #(.ACC_W(ACC_W), .SAMPLE_DIV(1), .INC_UNIT(INC)) dut (
    .clk     (clk),
    .rst     (rst),
    .wave_io (wif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sample;
    logic       cs;
    logic [7:0] p;
  } exp_t;

  exp_t sb[$];
  int   sq [64];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_acc = '0;
  int          m_fs = 0, m_as = 0, m_ws = 0;

  logic       obs_fresh = 1'b0;
  logic       obs_cs = 1'b0;
  logic [7:0] obs_p = '0;
  logic [7:0] obs_sample = '0;

  function automatic int shape(input int p, input int w);
    int i, q;
    i = p % 64;
    q = ((p / 64) % 2 == 1) ? sq[63 - i] : sq[i];
    case (w)
      0:       return (p < 128) ? 127 : -128;
      1:       return (p < 128) ? (2 * p - 128) : (127 - 2 * (p - 128));
      2:       return p - 128;
      default: return (p >= 128) ? -q : q;
    endcase
  endfunction

  // Reference model: one expected sample per tick (every clk here)
  initial begin
    forever begin
      logic [32:0] sum;
      logic        wrap;
      int          p, e;
      exp_t        ent;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_acc = '0; m_fs = 0; m_as = 0; m_ws = 0;
        sb.delete();
      end else begin
        wrap = 1'b0;
        if (m_fs == 0) begin
          m_fs = int'(wif.frequency); m_as = int'(wif.amplitude); m_ws = int'(wif.wave_type);
        end else begin
          sum   = {1'b0, m_acc} + 33'(m_fs) * 33'(INC);
          m_acc = sum[31:0];
          wrap  = sum[32];
          if (wrap) begin
            m_fs = int'(wif.frequency); m_as = int'(wif.amplitude); m_ws = int'(wif.wave_type);
          end
        end
        p = int'(m_acc[31:24]);
        e = ((shape(p, m_ws) * m_as) >>> 4) + 128;
        ent.sample = 8'(e);
        ent.cs     = wrap;
        ent.p      = 8'(p);
        sb.push_back(ent);
      end
    end
  end

  // Scoreboard: every sample_valid pops and compares one expected entry
  initial begin
    forever begin
      exp_t x;
      @(negedge clk);
      obs_fresh = 1'b0;
      if (!rst && wif.sample_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: sample_valid with nothing expected at %0t", $time);
        end else begin
          x = sb.pop_front();
          if (wif.sample !== x.sample || wif.cycle_start !== x.cs) begin
            errors++;
            $display("FAIL sb_sample p=%0d: got sample=%0d cs=%b, want sample=%0d cs=%b at %0t",
                     x.p, wif.sample, wif.cycle_start, x.sample, x.cs, $time);
          end
          obs_p = x.p;
        end
        obs_fresh  = 1'b1;
        obs_sample = wif.sample;
        obs_cs     = wif.cycle_start;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic drive(input int f, input int a, input int w);
    wif.frequency = 7'(f);
    wif.amplitude = 4'(a);
    wif.wave_type = 2'(w);
  endtask

  task automatic wait_sample(input string what);
    bit ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk); #1;
      ok = obs_fresh;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: got no sample_valid, want one within 8 clk", what); end
  endtask

  task automatic wait_cs(input string what);
    bit ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk); #1;
      ok = obs_fresh && obs_cs;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: got no cycle_start, want one within 600 clk", what); end
  endtask

  task automatic wait_p(input int p, input string what);
    bit ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk); #1;
      ok = obs_fresh && (int'(obs_p) == p);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: got no sample at p=%0d, want one within 600 clk", what, p); end
  endtask

  task automatic test_reset();
    drive(5, 15, 2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (wif.sample !== 8'd128) begin errors++; $display("FAIL rst_sample: got %0d want 128", wif.sample); end
    checks++;
    if (wif.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", wif.sample_valid); end
    checks++;
    if (wif.cycle_start !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", wif.cycle_start); end
    drive(0, 15, 2);
    @(negedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wif.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_latency: got valid=%b want 0 before 4th clk", wif.sample_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (wif.sample_valid !== 1'b1 || wif.sample !== 8'd8) begin
        errors++;
        $display("FAIL stopped_hold[%0d]: got valid=%b sample=%0d want valid=1 sample=8", i, wif.sample_valid, wif.sample);
      end
    end
  endtask

  task automatic test_sawtooth();
    int n = 0;
    bit got = 1'b0;
    bit done = 1'b0;
    #1 rst = 1'b1;
    drive(1, 15, 2);
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      n++;
      got = (wif.sample_valid === 1'b1);
    end
    checks++;
    if (!got || n != 4) begin errors++; $display("FAIL saw_latency: got first valid at clk %0d want 4", n); end
    checks++;
    if (wif.sample !== 8'd8 || wif.cycle_start !== 1'b0) begin
      errors++; $display("FAIL saw_first: got sample=%0d cs=%b want 8 cs=0", wif.sample, wif.cycle_start);
    end
    wait_p(255, "saw_p255");
    checks++;
    if (obs_sample !== 8'd247) begin errors++; $display("FAIL saw_p255_val: got %0d want 247", obs_sample); end
    wait_cs("saw_wrap");
    n = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (obs_fresh) begin n++; done = obs_cs; end
    end
    checks++;
    if (!done || n != 256) begin errors++; $display("FAIL saw_period: got %0d samples want 256", n); end
  endtask

  task automatic test_square();
    int n = 0, hi = 0, lo = 0;
    bit done = 1'b0;
    drive(2, 8, 0);
    wait_cs("sq_load");
    checks++;
    if (obs_sample !== 8'd191) begin errors++; $display("FAIL sq_p0: got %0d want 191", obs_sample); end
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (obs_fresh) begin
        n++;
        if (obs_cs) done = 1'b1;
        else if (obs_sample == 8'd191) hi++;
        else if (obs_sample == 8'd64) lo++;
      end
    end
    checks++;
    if (!done || n != 128) begin errors++; $display("FAIL sq_period: got %0d samples want 128", n); end
    checks++;
    if (hi != 63 || lo != 64) begin errors++; $display("FAIL sq_levels: got hi=%0d lo=%0d want hi=63 lo=64", hi, lo); end
  endtask

  task automatic test_triangle();
    drive(2, 8, 1);
    wait_cs("tri_load");
    checks++;
    if (obs_sample !== 8'd64) begin errors++; $display("FAIL tri_p0: got %0d want 64", obs_sample); end
    wait_p(64, "tri_p64");
    checks++;
    if (obs_sample !== 8'd128) begin errors++; $display("FAIL tri_p64_val: got %0d want 128", obs_sample); end
    wait_p(128, "tri_p128");
    checks++;
    if (obs_sample !== 8'd191) begin errors++; $display("FAIL tri_p128_val: got %0d want 191", obs_sample); end
  endtask

  task automatic test_sine();
    drive(1, 15, 3);
    wait_cs("sin_load");
    checks++;
    if (obs_sample !== 8'd128) begin errors++; $display("FAIL sin_p0: got %0d want 128", obs_sample); end
    wait_p(64, "sin_p64");
    checks++;
    if (obs_sample !== 8'd247) begin errors++; $display("FAIL sin_p64_val: got %0d want 247", obs_sample); end
    wait_p(192, "sin_p192");
    checks++;
    if (obs_sample !== 8'd8) begin errors++; $display("FAIL sin_p192_val: got %0d want 8", obs_sample); end
  endtask

  task automatic test_mid_change();
    drive(1, 15, 1);
    wait_cs("mid_load");
    checks++;
    if (obs_sample !== 8'd8) begin errors++; $display("FAIL mid_p0: got %0d want 8", obs_sample); end
    wait_p(100, "mid_p100");
    drive(1, 0, 2);
    wait_p(255, "mid_p255");
    checks++;
    if (obs_sample !== 8'd8) begin errors++; $display("FAIL mid_unchanged: got %0d want 8", obs_sample); end
    wait_sample("mid_wrap");
    checks++;
    if (obs_cs !== 1'b1 || obs_sample !== 8'd128) begin
      errors++; $display("FAIL mid_wrap_val: got sample=%0d cs=%b want 128 cs=1", obs_sample, obs_cs);
    end
    for (int i = 0; i < 3; i++) begin
      wait_sample("mid_after");
      checks++;
      if (obs_sample !== 8'd128) begin errors++; $display("FAIL mid_zero[%0d]: got %0d want 128", i, obs_sample); end
    end
  endtask

  task automatic test_freq_change();
    bit found = 1'b0;
    drive(1, 15, 2);
    wait_cs("fc_load");
    wait_p(50, "fc_p50");
    drive(4, 15, 2);
    wait_p(255, "fc_p255");
    checks++;
    if (obs_sample !== 8'd247) begin errors++; $display("FAIL fc_step1: got %0d want 247", obs_sample); end
    wait_sample("fc_wrap");
    checks++;
    if (obs_cs !== 1'b1 || obs_sample !== 8'd8) begin
      errors++; $display("FAIL fc_wrap_val: got sample=%0d cs=%b want 8 cs=1", obs_sample, obs_cs);
    end
    wait_sample("fc_s4a");
    checks++;
    if (obs_sample !== 8'd11) begin errors++; $display("FAIL fc_step4a: got %0d want 11", obs_sample); end
    wait_sample("fc_s4b");
    checks++;
    if (obs_sample !== 8'd15) begin errors++; $display("FAIL fc_step4b: got %0d want 15", obs_sample); end
    drive(0, 15, 2);
    wait_cs("fc_stop_wrap");
    checks++;
    if (obs_sample !== 8'd8) begin errors++; $display("FAIL fc_stop_wrap_val: got %0d want 8", obs_sample); end
    for (int i = 0; i < 4; i++) begin
      wait_sample("fc_hold");
      checks++;
      if (obs_sample !== 8'd8 || obs_cs !== 1'b0) begin
        errors++; $display("FAIL fc_hold[%0d]: got sample=%0d cs=%b want 8 cs=0", i, obs_sample, obs_cs);
      end
    end
    drive(3, 15, 2);
    for (int i = 0; i < 8 && !found; i++) begin
      wait_sample("fc_restart");
      found = (obs_sample !== 8'd8);
    end
    checks++;
    if (!found || obs_sample !== 8'd10) begin
      errors++; $display("FAIL fc_restart_val: got %0d want 10 within 8 samples", obs_sample);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      sq[i] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0) + 0.5);
    drive(0, 0, 0);
    test_reset();
    test_sawtooth();
    test_square();
    test_triangle();
    test_sine();
    test_mid_change();
    test_freq_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
